demux_rx: RTL and testbench
===========================

DEMUX_RX -- requirements
Module: demux_rx

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, number of synchronizer flops per input (legal range 2..4).
REQ-002 SHALL have port clk  input  1  single system clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous to clk and active-high.
REQ-004 SHALL have port ena  input  1  switch enable from the controller, active-high; asynchronous to clk.
REQ-005 SHALL have port wr  input  1  write strobe, active-low; the address is latched on its rising edge; asynchronous to clk.
REQ-006 SHALL have port cs  input  1  chip select, active-low; asynchronous to clk.
REQ-007 SHALL have port set_ch  input  5  channel address.
REQ-008 SHALL have port ch  output  5  last committed channel.
REQ-009 SHALL have port ch_valid  output  1  high once any write has committed since reset.
REQ-010 SHALL have port sw_on  output  1  switch closed: ch_valid AND synchronized ena.
REQ-011 SHALL have port ch_onehot  output  32  one-hot of ch, gated by sw_on.
REQ-012 SHALL have port wr_strobe  output  1  one-cycle pulse on each commit.
REQ-013 SHALL have port err_pulse  output  1  one-cycle pulse on each protocol error.
REQ-014 SHALL have port wr_count  output  8  number of commits, wraps 255->0.

Function
REQ-015 SHALL pass ena, wr, cs and set_ch each through SYNC_STAGES flops; the FSM SHALL use only the synchronized values (ena_s, wr_s, cs_s, ch_s).
REQ-016 SHALL implement the FSM states IDLE, SEL and WRITE.
REQ-017 IDLE SHALL go to SEL when cs_s=0 and wr_s=1, and SHALL go directly to WRITE when cs_s=0 and wr_s=0.
REQ-018 SEL SHALL go to WRITE when wr_s=0 and SHALL go to IDLE when cs_s=1 and wr_s=1.
REQ-019 SHALL register ch_s into addr_hold on every cycle spent in WRITE.
REQ-020 Commit: in WRITE with wr_s=1, the block SHALL load ch with addr_hold, set ch_valid, pulse wr_strobe and increment wr_count.
REQ-021 After a commit, the FSM SHALL go to SEL if cs_s=0, else to IDLE; a simultaneous rise of cs_s and wr_s SHALL count as a commit.
REQ-022 Abort: in WRITE with cs_s=1 and wr_s=0, the block SHALL go to IDLE, SHALL NOT commit, and SHALL pulse err_pulse.
REQ-023 Stray write: in IDLE, a wr_s falling edge with cs_s=1 SHALL pulse err_pulse and SHALL leave the state unchanged.
REQ-024 ch, ch_valid, wr_strobe and wr_count SHALL update on clock edge SYNC_STAGES+1, counting from the first edge that samples raw wr high; this edge is called the commit edge.
REQ-025 sw_on SHALL follow raw ena with a latency of SYNC_STAGES+1 edges; ch_onehot SHALL be registered alongside sw_on.
REQ-026 ena SHALL NOT affect address latching; ch SHALL be retained while ena=0.
REQ-027 Back-to-back writes with cs held low SHALL each commit independently.
REQ-028 wr_strobe and err_pulse SHALL never be high in the same cycle.

Reset
REQ-029 While rst=1, the block SHALL set state=IDLE, ch=0, ch_valid=0, sw_on=0, ch_onehot=0, wr_strobe=0, err_pulse=0, wr_count=0 and addr_hold=0.
REQ-030 While rst=1, the synchronizer flops SHALL be preset to idle levels: cs=1, wr=1, ena=0, set_ch=0.
REQ-031 A reset asserted during WRITE SHALL discard the pending write with no commit and no err_pulse.
REQ-032 The first cycle after rst deasserts SHALL evaluate only synchronized inputs; inputs already low SHALL be treated as new edges only after propagating through the synchronizer.

Configuration
REQ-033 SHALL use the macro DEMUX_RX_ONEHOT_EN.
REQ-034 With DEMUX_RX_ONEHOT_EN defined, ch_onehot SHALL be the 32-bit decoder of REQ-011 and REQ-025.
REQ-035 Without DEMUX_RX_ONEHOT_EN, ch_onehot SHALL be tied to 0 with no decoder logic, and all other behaviour SHALL be unchanged.

Verification
REQ-036 Normal write: cs=0, set_ch=13, wr low for 3 cycles then high, ena=1 -> at the commit edge: ch=13, ch_valid=1, wr_strobe one pulse, wr_count=1; sw_on=1; ch_onehot=0x00002000.
REQ-037 Abort: cs=0, wr=0, set_ch=7, then cs=1 while wr=0 -> err_pulse one pulse; ch and wr_count unchanged; state IDLE.
REQ-038 Stray write: cs=1, wr pulsed low for 2 cycles -> err_pulse one pulse; no commit.
REQ-039 Three back-to-back writes of 1, 31, 0 with cs held low -> three wr_strobe pulses; ch ends at 0; wr_count=3; ch_onehot=0x00000001 with ena=1.
REQ-040 Wrap and gating: 256 commits -> wr_count=0; then ena=0 -> sw_on=0 and ch_onehot=0 after SYNC_STAGES+1 cycles, ch retained.
REQ-041 Reset mid-write: rst=1 during WRITE -> all outputs at reset values, no err_pulse; a subsequent wr rise while cs=0 without a preceding wr fall produces no commit.

Source files
------------

// File: rtl/demux_rx.sv
// Channel-select receiver: synchronizes an asynchronous cs/wr/set_ch/ena bus and commits the channel address on the rising edge of wr.
// Optional macro DEMUX_RX_ONEHOT_EN enables the registered 32-bit one-hot channel decoder on ch_onehot.
module demux_rx #(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ena,
    input  logic        wr,
    input  logic        cs,
    input  logic [4:0]  set_ch,
    output logic [4:0]  ch,
    output logic        ch_valid,
    output logic        sw_on,
    output logic [31:0] ch_onehot,
    output logic        wr_strobe,
    output logic        err_pulse,
    output logic [7:0]  wr_count
);

    // state | meaning
    // IDLE  | bus deselected, waiting for cs
    // SEL   | cs asserted, waiting for wr to fall
    // WRITE | wr low, capturing the address until wr rises (commit) or cs drops (abort)
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEL   = 2'd1,
        WRITE = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [SYNC_STAGES-1:0] ena_sync_q;
    logic [SYNC_STAGES-1:0] wr_sync_q;
    logic [SYNC_STAGES-1:0] cs_sync_q;
    logic [4:0]             ch_sync_q [SYNC_STAGES];

    logic       ena_s, wr_s, cs_s;
    logic [4:0] ch_s;
    logic       wr_prev_q;

    logic [4:0] addr_hold_q, addr_hold_d;
    logic [4:0] ch_q, ch_d;
    logic       ch_valid_q, ch_valid_d;
    logic       sw_on_q, sw_on_d;
    logic       wr_strobe_q, wr_strobe_d;
    logic       err_pulse_q, err_pulse_d;
    logic [7:0] wr_count_q, wr_count_d;

    logic commit, abort, stray;

    // Synchronizers preset to the idle bus levels so a held-low input is seen as a fresh edge after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            ena_sync_q <= '0;
            wr_sync_q  <= '1;
            cs_sync_q  <= '1;
            for (int i = 0; i < SYNC_STAGES; i++) begin
                ch_sync_q[i] <= '0;
            end
            wr_prev_q  <= 1'b1;
        end else begin
            ena_sync_q   <= {ena_sync_q[SYNC_STAGES-2:0], ena};
            wr_sync_q    <= {wr_sync_q[SYNC_STAGES-2:0], wr};
            cs_sync_q    <= {cs_sync_q[SYNC_STAGES-2:0], cs};
            ch_sync_q[0] <= set_ch;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                ch_sync_q[i] <= ch_sync_q[i-1];
            end
            wr_prev_q    <= wr_s;
        end
    end

    assign ena_s = ena_sync_q[SYNC_STAGES-1];
    assign wr_s  = wr_sync_q[SYNC_STAGES-1];
    assign cs_s  = cs_sync_q[SYNC_STAGES-1];
    assign ch_s  = ch_sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (!cs_s) begin
                    state_d = wr_s ? SEL : WRITE;
                end
            end
            SEL: begin
                if (!wr_s) begin
                    state_d = WRITE;
                end else if (cs_s) begin
                    state_d = IDLE;
                end
            end
            WRITE: begin
                if (wr_s) begin
                    state_d = cs_s ? IDLE : SEL;
                end else if (cs_s) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        commit = (state_q == WRITE) && wr_s;
        abort  = (state_q == WRITE) && !wr_s && cs_s;
        stray  = (state_q == IDLE) && cs_s && wr_prev_q && !wr_s;

        // Also capture on entry so a single-cycle wr low still commits the address it carried.
        addr_hold_d = ((state_q == WRITE) || (state_d == WRITE)) ? ch_s : addr_hold_q;
        ch_d        = commit ? addr_hold_q : ch_q;
        ch_valid_d  = ch_valid_q | commit;
        wr_count_d  = wr_count_q + {7'd0, commit};
        sw_on_d     = ch_valid_d & ena_s;
        wr_strobe_d = commit;
        err_pulse_d = abort | stray;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_hold_q <= '0;
            ch_q        <= '0;
            ch_valid_q  <= 1'b0;
            sw_on_q     <= 1'b0;
            wr_strobe_q <= 1'b0;
            err_pulse_q <= 1'b0;
            wr_count_q  <= '0;
        end else begin
            addr_hold_q <= addr_hold_d;
            ch_q        <= ch_d;
            ch_valid_q  <= ch_valid_d;
            sw_on_q     <= sw_on_d;
            wr_strobe_q <= wr_strobe_d;
            err_pulse_q <= err_pulse_d;
            wr_count_q  <= wr_count_d;
        end
    end

`ifdef DEMUX_RX_ONEHOT_EN
    logic [31:0] onehot_q, onehot_d;

    always_comb begin
        onehot_d = sw_on_d ? (32'd1 << ch_d) : 32'd0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            onehot_q <= '0;
        end else begin
            onehot_q <= onehot_d;
        end
    end

    assign ch_onehot = onehot_q;
`else
    assign ch_onehot = 32'd0;
`endif

    assign ch        = ch_q;
    assign ch_valid  = ch_valid_q;
    assign sw_on     = sw_on_q;
    assign wr_strobe = wr_strobe_q;
    assign err_pulse = err_pulse_q;
    assign wr_count  = wr_count_q;

    a_strobe_err_excl: assert property (@(posedge clk) disable iff (rst) !(wr_strobe && err_pulse));

endmodule

// File: tb/tb_demux_rx.sv
// Scoreboard bench for demux_rx: commits are predicted when wr is raised and checked when wr_strobe fires.
module tb_demux_rx;

    localparam int S = 2;

    logic        clk = 1'b0;
    logic        rst, ena, wr, cs;
    logic [4:0]  set_ch;
    logic [4:0]  ch;
    logic        ch_valid, sw_on, wr_strobe, err_pulse;
    logic [31:0] ch_onehot;
    logic [7:0]  wr_count;

    int vec_cnt  = 0;
    int miss_cnt = 0;
    int strobe_cnt = 0;
    int err_cnt    = 0;

    logic [12:0] exp_q [$];
    logic [7:0]  exp_cnt;
    logic [4:0]  exp_ch;

    demux_rx #(.SYNC_STAGES(S)) dut (
        .clk(clk), .rst(rst), .ena(ena), .wr(wr), .cs(cs), .set_ch(set_ch),
        .ch(ch), .ch_valid(ch_valid), .sw_on(sw_on), .ch_onehot(ch_onehot),
        .wr_strobe(wr_strobe), .err_pulse(err_pulse), .wr_count(wr_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            miss_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [31:0] onehot_exp(input logic [4:0] c, input logic on);
`ifdef DEMUX_RX_ONEHOT_EN
        onehot_exp = on ? (32'd1 << c) : 32'd0;
`else
        onehot_exp = 32'd0;
`endif
    endfunction

    // Commit monitor: every strobe must match the oldest predicted commit.
    always @(negedge clk) begin
        if (!rst) begin
            if (wr_strobe || err_pulse) check("strobe_err_excl", {31'd0, wr_strobe & err_pulse}, 32'd0);
            if (err_pulse) err_cnt++;
            if (wr_strobe) begin
                strobe_cnt++;
                if (exp_q.size() == 0) begin
                    check("unexpected_strobe", 32'd1, 32'd0);
                end else begin
                    logic [12:0] e;
                    e = exp_q.pop_front();
                    check("commit_ch", {27'd0, ch}, {27'd0, e[12:8]});
                    check("commit_count", {24'd0, wr_count}, {24'd0, e[7:0]});
                    check("commit_valid", {31'd0, ch_valid}, 32'd1);
                end
            end
        end
    end

    task automatic predict(input logic [4:0] a);
        exp_cnt = exp_cnt + 8'd1;
        exp_ch  = a;
        exp_q.push_back({a, exp_cnt});
    endtask

    task automatic do_write(input logic [4:0] a, input int low_cycles);
        set_ch = a;
        wr = 1'b0;
        cyc(low_cycles);
        wr = 1'b1;
        predict(a);
        cyc(2);
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        cyc(3);
        rst = 1'b0;
        exp_cnt = 8'd0;
        exp_ch  = 5'd0;
        cyc(S + 3);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ch"}, {27'd0, ch}, 32'd0);
        check({tag, "_valid"}, {31'd0, ch_valid}, 32'd0);
        check({tag, "_sw_on"}, {31'd0, sw_on}, 32'd0);
        check({tag, "_onehot"}, ch_onehot, 32'd0);
        check({tag, "_strobe"}, {31'd0, wr_strobe}, 32'd0);
        check({tag, "_err"}, {31'd0, err_pulse}, 32'd0);
        check({tag, "_count"}, {24'd0, wr_count}, 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int e0, s0;
        rst = 1'b1; ena = 1'b0; wr = 1'b1; cs = 1'b1; set_ch = 5'd0;
        exp_cnt = 8'd0; exp_ch = 5'd0;
        cyc(3);
        check_reset_outputs("reset");
        rst = 1'b0;
        cyc(S + 3);

        // Normal write of channel 13 with cycle-exact commit edge.
        ena = 1'b1; cs = 1'b0; set_ch = 5'd13;
        cyc(1);
        wr = 1'b0;
        cyc(3);
        wr = 1'b1;
        predict(5'd13);
        cyc(S);
        check("pre_commit_strobe", {31'd0, wr_strobe}, 32'd0);
        check("pre_commit_sw_on", {31'd0, sw_on}, 32'd0);
        cyc(1);
        check("commit_edge_strobe", {31'd0, wr_strobe}, 32'd1);
        check("normal_ch", {27'd0, ch}, 32'd13);
        check("normal_count", {24'd0, wr_count}, 32'd1);
        check("normal_sw_on", {31'd0, sw_on}, 32'd1);
        check("normal_onehot", ch_onehot, onehot_exp(5'd13, 1'b1));
        cyc(1);
        check("strobe_one_pulse", {31'd0, wr_strobe}, 32'd0);
        cs = 1'b1;
        cyc(S + 3);

        // Abort: cs released while wr still low.
        e0 = err_cnt; s0 = strobe_cnt;
        cs = 1'b0; wr = 1'b0; set_ch = 5'd7;
        cyc(4);
        cs = 1'b1;
        cyc(S + 3);
        wr = 1'b1;
        cyc(S + 3);
        check("abort_err", err_cnt - e0, 32'd1);
        check("abort_no_strobe", strobe_cnt - s0, 32'd0);
        check("abort_ch", {27'd0, ch}, {27'd0, exp_ch});
        check("abort_count", {24'd0, wr_count}, {24'd0, exp_cnt});

        // Stray write with cs deasserted; only reported from IDLE, so also confirms the abort landed there.
        e0 = err_cnt; s0 = strobe_cnt;
        wr = 1'b0;
        cyc(2);
        wr = 1'b1;
        cyc(S + 3);
        check("stray_err", err_cnt - e0, 32'd1);
        check("stray_no_strobe", strobe_cnt - s0, 32'd0);
        check("queue_drained_1", exp_q.size(), 32'd0);

        // Back-to-back writes from a clean reset.
        apply_reset();
        s0 = strobe_cnt;
        cs = 1'b0;
        cyc(1);
        do_write(5'd1, 3);
        do_write(5'd31, 2);
        do_write(5'd0, 2);
        cyc(S + 3);
        check("b2b_strobes", strobe_cnt - s0, 32'd3);
        check("b2b_ch", {27'd0, ch}, 32'd0);
        check("b2b_count", {24'd0, wr_count}, 32'd3);
        check("b2b_onehot", ch_onehot, onehot_exp(5'd0, 1'b1));

        // Wrap the commit counter, mixing in single-cycle wr lows.
        for (int i = 0; i < 253; i++) begin
            do_write(5'($urandom_range(0, 31)), (i % 3 == 0) ? 1 : 2);
        end
        cs = 1'b1;
        cyc(S + 3);
        check("wrap_count", {24'd0, wr_count}, 32'd0);
        check("wrap_ch", {27'd0, ch}, {27'd0, exp_ch});
        check("queue_drained_2", exp_q.size(), 32'd0);

        // Enable gating latency; channel must be retained.
        ena = 1'b0;
        cyc(S);
        check("gate_sw_on_before", {31'd0, sw_on}, 32'd1);
        cyc(1);
        check("gate_sw_on_after", {31'd0, sw_on}, 32'd0);
        check("gate_onehot", ch_onehot, 32'd0);
        check("gate_ch_kept", {27'd0, ch}, {27'd0, exp_ch});
        check("gate_valid_kept", {31'd0, ch_valid}, 32'd1);

        // Reset in the middle of a write; wr rises while still in reset.
        e0 = err_cnt; s0 = strobe_cnt;
        ena = 1'b1; cs = 1'b0; wr = 1'b0; set_ch = 5'd9;
        cyc(S + 3);
        rst = 1'b1;
        cyc(1);
        check_reset_outputs("midwr_reset");
        wr = 1'b1;
        cyc(2);
        rst = 1'b0;
        exp_cnt = 8'd0; exp_ch = 5'd0;
        cyc(S + 5);
        check("midwr_no_strobe", strobe_cnt - s0, 32'd0);
        check("midwr_no_err", err_cnt - e0, 32'd0);
        check("midwr_ch", {27'd0, ch}, 32'd0);
        check("midwr_valid", {31'd0, ch_valid}, 32'd0);
        check("midwr_count", {24'd0, wr_count}, 32'd0);
        cs = 1'b1;
        cyc(S + 3);
        check("queue_drained_3", exp_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule
